mem_arbiter: RTL

- Arbitrates a single unified RAM port between instruction fetch (icache/imem side) and data access (dcache/dmem side) of the pipelined core.
- One grant at a time. Data requests have priority; a starvation guard bounds consecutive data grants while a fetch waits.
- Returns per-side wait/load to the caches; drives RAM REN/WEN/addr/store.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter_streak_cnt.sv | 35 +++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared CPU memory types: RAM handshake state, word type and the arbiter FSM encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signals of the unified memory port.
// master = the arbiter; slave = the caches plus the RAM around it.
interface mem_arbiter_if #(
    parameter int WORD_W = 32
);
    import cpu_types_pkg::*;

    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    ramstate_t         ramstate;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter_streak_cnt.sv
// Saturating count of back-to-back data completions taken while a fetch waits.
// sat_o is registered state; clear has priority over increment.
module arb_streak_cnt #(
    parameter int MAX = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);
    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign sat_o = (cnt_q == W'(MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Unified RAM port arbiter: data first, fetch forced after DSTREAK_MAX data wins; 2-cycle min latency.
// Optional MEM_ARBITER_PERF_CNT_EN adds icount/dcount/stallcount outputs.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DSTREAK_MAX = 4,
    parameter int WORD_W      = 32
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.master bus
`ifdef MEM_ARBITER_PERF_CNT_EN
    ,
    output word_t         icount,
    output word_t         dcount,
    output word_t         stallcount
`endif
);
    localparam logic [WORD_W-1:0] ZERO_W = '0;

    arb_state_t state_q;
    arb_state_t state_d;

    logic dreq;
    logic d_done;
    logic i_done;
    logic force_i;
    logic streak_sat;
    logic iwait_c;
    logic dwait_c;

    assign dreq    = bus.dREN | bus.dWEN;
    assign d_done  = (state_q == DGRANT) && (bus.ramstate == ACCESS) && dreq;
    assign i_done  = (state_q == IGRANT) && (bus.ramstate == ACCESS) && bus.iREN;
    assign force_i = bus.iREN & streak_sat;

    // Streak only grows while a fetch is actually waiting behind the data side.
    arb_streak_cnt #(
        .MAX (DSTREAK_MAX)
    ) u_streak (
        .CLK   (CLK),
        .RST   (RST),
        .inc_i (d_done & bus.iREN),
        .clr_i (i_done | ~bus.iREN),
        .sat_o (streak_sat)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dreq && !force_i) begin
                    state_d = DGRANT;
                end else if (bus.iREN) begin
                    state_d = IGRANT;
                end
            end
            DGRANT: begin
                if (!dreq || bus.ramstate == ACCESS || bus.ramstate == ERROR) begin
                    state_d = IDLE;
                end
            end
            IGRANT: begin
                if (!bus.iREN || bus.ramstate == ACCESS || bus.ramstate == ERROR) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = ZERO_W;
        bus.ramstore = ZERO_W;
        iwait_c      = 1'b1;
        dwait_c      = 1'b1;
        case (state_q)
            DGRANT: begin
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramWEN   = bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                dwait_c      = ~d_done;
            end
            IGRANT: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                iwait_c     = ~i_done;
            end
            default: ;
        endcase
    end

    assign bus.iwait = iwait_c;
    assign bus.dwait = dwait_c;
    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;

`ifdef MEM_ARBITER_PERF_CNT_EN
    word_t icount_q;
    word_t dcount_q;
    word_t stall_q;
    logic  stall_c;

    assign stall_c = (bus.iREN & iwait_c) | (dreq & dwait_c);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            icount_q <= '0;
            dcount_q <= '0;
            stall_q  <= '0;
        end else begin
            if (i_done)  icount_q <= icount_q + 32'd1;
            if (d_done)  dcount_q <= dcount_q + 32'd1;
            if (stall_c) stall_q  <= stall_q + 32'd1;
        end
    end

    assign icount     = icount_q;
    assign dcount     = dcount_q;
    assign stallcount = stall_q;
`endif
endmodule
